rv32i_pipe_ctrl: RTL and testbench
==================================

# rv32i_pipe_ctrl

Pipeline control sequencer for the 5-stage RV32I core. It takes the per-instruction control word from the ID-stage main decoder and carries it through the ID/EX, EX/MEM and MEM/WB control registers. It detects load-use hazards and taken branches, and generates stall, flush and EX-stage forwarding selects. It also keeps saturating stall and flush event counters for bring-up.

## Interface
Parameters:
- CNT_W, 16, width of each saturating event counter

Ports (name, direction, width, meaning):
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- RegWriteD, MemWriteD, ResultSrcD, ALUSrcD, BranchD  in  1 each  ID control from main decoder
- ALUOpD  in  2  ID ALU op class
- Rs1D, Rs2D, RdD  in  5 each  ID register fields (raw instruction bits)
- ZeroE  in  1  ALU zero flag of the EX instruction
- StallF, StallD  out  1 each  hold PC / IF-ID register
- FlushD, FlushE  out  1 each  bubble IF-ID / ID-EX next edge
- PCSrcE  out  1  select branch target
- ForwardAE, ForwardBE  out  2 each  EX operand select: 00 regfile, 01 WB result, 10 MEM ALU result
- RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE  out  1 each; ALUOpE  out  2; Rs1E, Rs2E, RdE  out  5  EX-stage control (registered)
- RegWriteM, MemWriteM, ResultSrcM  out  1 each; RdM  out  5  MEM-stage control (registered)
- RegWriteW, ResultSrcW  out  1 each; RdW  out  5  WB-stage control (registered)
- StallCnt, FlushCnt  out  CNT_W each  saturating event counters

## Operation
- Bubble: all control bits 0, ALUOpE=00, Rs1E/Rs2E/RdE=0.
- PCSrcE = BranchE & ZeroE.
- Load-use hazard lu = ResultSrcE & RegWriteE & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D). Comparison uses the raw fields regardless of format. The resulting conservative stalls are required behaviour.
- Priority: if PCSrcE=1, then FlushD=1, FlushE=1, StallF=StallD=0, and lu is ignored. Otherwise, if lu=1, then StallF=StallD=1, FlushE=1, FlushD=0. Otherwise all four are 0.
- ID/EX update: FlushE=1 loads a bubble. Otherwise it loads the D inputs.
- EX/MEM update: always loads from EX. The MEM and WB stages never stall.
- MEM/WB update: always loads from MEM.
- ForwardAE = 10 when RegWriteM & RdM!=0 & RdM==Rs1E. Otherwise it is 01 when RegWriteW & RdW!=0 & RdW==Rs1E. Otherwise 00. MEM has priority over WB.
- ForwardBE is computed the same way using Rs2E.
- StallCnt increments by 1 on each edge where lu=1 and PCSrcE=0.
- FlushCnt increments by 1 on each edge where PCSrcE=1.
- Both counters saturate at 2^CNT_W-1. They do not wrap.

## Timing
- Hazard, forward and PCSrcE outputs are combinational from the current registered state and the D inputs, within the same cycle.
- Register updates happen on the rising edge of clk.
- A D-stage control word appears on the E outputs 1 cycle later, on the M outputs 2 cycles later and on the W outputs 3 cycles later.
- Load-use costs exactly 1 bubble. In the next cycle RegWriteE=0, so lu deasserts.
- A taken branch inserts 2 bubbles: the D and E instructions are squashed on the same edge.
- rst=1 asynchronously clears all registered outputs and counters to 0, including mid-stream. As a result, all combinational outputs read 0 while rst is held.
- The first edge after rst deasserts loads the D inputs normally.

## Test plan
- Reset mid-stream: assert rst asynchronously with RegWriteM=1 and StallCnt=5. Required: all registered outputs and counters read 0 before the next clk edge, and PCSrcE=0.
- Load-use hazard: EX holds a lw with RdE=5; D presents add with Rs1D=5. Required: StallF=StallD=FlushE=1 that cycle; next cycle RegWriteE=0 and StallCnt=1; the following cycle ForwardAE=01 for the add in EX.
- Forwarding priority: RdM=RdW=7, RegWriteM=RegWriteW=1, Rs1E=7, Rs2E=0. Required: ForwardAE=10 and ForwardBE=00. Repeat with RdM=0: required ForwardAE=01.
- Branch taken with simultaneous lu: BranchE=1, ZeroE=1 and an lu condition present. Required: PCSrcE=1, FlushD=FlushE=1, StallF=StallD=0, FlushCnt increments by 1 and StallCnt is unchanged.
- Counter saturation: with CNT_W=4, apply 20 consecutive taken-branch cycles. Required: FlushCnt holds at 15.
- Pipeline latency: apply a sw control word at D. Required: MemWriteE=1 at +1 cycle, MemWriteM=1 at +2 cycles and RegWriteW=0 at +3 cycles.

Source files
------------

// File: rtl/rv32i_pipe_ctrl.sv
// rv32i_pipe_ctrl: pipeline control registers, hazard detection, forwarding and event counters
module rv32i_pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             ResultSrcD,
  input  logic             ALUSrcD,
  input  logic             BranchD,
  input  logic [1:0]       ALUOpD,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             ZeroE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             PCSrcE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             ResultSrcE,
  output logic             ALUSrcE,
  output logic             BranchE,
  output logic [1:0]       ALUOpE,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             ResultSrcM,
  output logic [4:0]       RdM,
  output logic             RegWriteW,
  output logic             ResultSrcW,
  output logic [4:0]       RdW,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);
  logic lu;
  always_comb begin
    PCSrcE = BranchE & ZeroE;
    lu = ResultSrcE & RegWriteE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
    StallF = lu & ~PCSrcE;
    StallD = lu & ~PCSrcE;
    FlushD = PCSrcE;
    FlushE = PCSrcE | lu;
    ForwardAE = (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? 2'b10 :
                (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? 2'b01 : 2'b00;
    ForwardBE = (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? 2'b10 :
                (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? 2'b01 : 2'b00;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, ALUOpE, Rs1E, Rs2E, RdE} <= '0;
      {RegWriteM, MemWriteM, ResultSrcM, RdM} <= '0;
      {RegWriteW, ResultSrcW, RdW} <= '0;
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      {RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, ALUOpE, Rs1E, Rs2E, RdE} <= FlushE ? 22'd0 :
        {RegWriteD, MemWriteD, ResultSrcD, ALUSrcD, BranchD, ALUOpD, Rs1D, Rs2D, RdD};
      {RegWriteM, MemWriteM, ResultSrcM, RdM} <= {RegWriteE, MemWriteE, ResultSrcE, RdE};
      {RegWriteW, ResultSrcW, RdW} <= {RegWriteM, ResultSrcM, RdM};
      if (StallF && !(&StallCnt)) StallCnt <= StallCnt + CNT_W'(1);
      if (PCSrcE && !(&FlushCnt)) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// tb_rv32i_pipe_ctrl: vector table, directed corner sequences and randomized run against a stage-list model
module tb_rv32i_pipe_ctrl;
  typedef struct packed {
    logic       rw, mw, rs, alus, br;
    logic [1:0] op;
    logic [4:0] r1, r2, rd;
  } cw_t;
  typedef struct {
    cw_t        d;
    logic       z;
    logic [8:0] comb;
    logic [3:0] st;
  } vec_t;

  localparam cw_t LW   = '{rw:1'b1, mw:1'b0, rs:1'b1, alus:1'b1, br:1'b0, op:2'd0, r1:5'd1, r2:5'd0, rd:5'd5};
  localparam cw_t ADD  = '{rw:1'b1, mw:1'b0, rs:1'b0, alus:1'b0, br:1'b0, op:2'd2, r1:5'd5, r2:5'd2, rd:5'd6};
  localparam cw_t SW   = '{rw:1'b0, mw:1'b1, rs:1'b0, alus:1'b1, br:1'b0, op:2'd0, r1:5'd2, r2:5'd6, rd:5'd0};
  localparam cw_t BEQ  = '{rw:1'b0, mw:1'b0, rs:1'b0, alus:1'b0, br:1'b1, op:2'd1, r1:5'd1, r2:5'd2, rd:5'd0};
  localparam cw_t ADD1 = '{rw:1'b1, mw:1'b0, rs:1'b0, alus:1'b0, br:1'b0, op:2'd2, r1:5'd3, r2:5'd4, rd:5'd1};
  localparam cw_t LDBR = '{rw:1'b1, mw:1'b0, rs:1'b1, alus:1'b1, br:1'b1, op:2'd0, r1:5'd0, r2:5'd0, rd:5'd5};
  localparam cw_t NOP  = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  cw_t  d = '0;
  logic ZeroE = 1'b0;
  logic RegWriteD, MemWriteD, ResultSrcD, ALUSrcD, BranchD;
  logic [1:0] ALUOpD;
  logic [4:0] Rs1D, Rs2D, RdD;
  assign {RegWriteD, MemWriteD, ResultSrcD, ALUSrcD, BranchD, ALUOpD, Rs1D, Rs2D, RdD} = d;

  logic StallF, StallD, FlushD, FlushE, PCSrcE;
  logic [1:0] ForwardAE, ForwardBE, ALUOpE;
  logic RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE;
  logic [4:0] Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, MemWriteM, ResultSrcM, RegWriteW, ResultSrcW;
  logic [15:0] StallCnt, FlushCnt;

  logic q_sf, q_sd, q_fd, q_fe, q_pc, q_rwe, q_mwe, q_rse, q_ase, q_bre;
  logic [1:0] q_fa, q_fb, q_op;
  logic [4:0] q_r1, q_r2, q_rde, q_rdm, q_rdw;
  logic q_rwm, q_mwm, q_rsm, q_rww, q_rsw;
  logic [3:0] q_sc, q_fc;

  always #5 clk = ~clk;

  rv32i_pipe_ctrl dut (
    .clk(clk), .rst(rst), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD),
    .ALUSrcD(ALUSrcD), .BranchD(BranchD), .ALUOpD(ALUOpD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ZeroE(ZeroE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .PCSrcE(PCSrcE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .ALUSrcE(ALUSrcE), .BranchE(BranchE), .ALUOpE(ALUOpE), .Rs1E(Rs1E),
    .Rs2E(Rs2E), .RdE(RdE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RdM(RdM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW), .StallCnt(StallCnt),
    .FlushCnt(FlushCnt)
  );

  rv32i_pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD),
    .ALUSrcD(ALUSrcD), .BranchD(BranchD), .ALUOpD(ALUOpD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ZeroE(ZeroE), .StallF(q_sf), .StallD(q_sd), .FlushD(q_fd), .FlushE(q_fe), .PCSrcE(q_pc),
    .ForwardAE(q_fa), .ForwardBE(q_fb), .RegWriteE(q_rwe), .MemWriteE(q_mwe), .ResultSrcE(q_rse),
    .ALUSrcE(q_ase), .BranchE(q_bre), .ALUOpE(q_op), .Rs1E(q_r1), .Rs2E(q_r2), .RdE(q_rde),
    .RegWriteM(q_rwm), .MemWriteM(q_mwm), .ResultSrcM(q_rsm), .RdM(q_rdm), .RegWriteW(q_rww),
    .ResultSrcW(q_rsw), .RdW(q_rdw), .StallCnt(q_sc), .FlushCnt(q_fc)
  );

  logic [8:0]  comb_a;
  logic [21:0] e_a;
  logic [7:0]  m_a;
  logic [6:0]  w_a;
  assign comb_a = {StallF, StallD, FlushD, FlushE, PCSrcE, ForwardAE, ForwardBE};
  assign e_a = {RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, ALUOpE, Rs1E, Rs2E, RdE};
  assign m_a = {RegWriteM, MemWriteM, ResultSrcM, RdM};
  assign w_a = {RegWriteW, ResultSrcW, RdW};

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: a list of in-flight control words (E, M, W) plus event tallies
  cw_t ms[3];
  int  mstall, mflush;

  function automatic logic [1:0] fwd(input logic [4:0] r);
    if (ms[1].rw && ms[1].rd != 0 && ms[1].rd == r) return 2'b10;
    if (ms[2].rw && ms[2].rd != 0 && ms[2].rd == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic hazard(input cw_t dd);
    return ms[0].rs && ms[0].rw && ms[0].rd != 0 && (ms[0].rd == dd.r1 || ms[0].rd == dd.r2);
  endfunction

  function automatic logic [8:0] exp_comb(input cw_t dd, input logic z);
    logic pc, st;
    pc = ms[0].br & z;
    st = hazard(dd) && !pc;
    return {st, st, pc, pc || st, pc, fwd(ms[0].r1), fwd(ms[0].r2)};
  endfunction

  task automatic model_reset;
    for (int i = 0; i < 3; i++) ms[i] = '0;
    mstall = 0;
    mflush = 0;
  endtask

  task automatic model_step(input cw_t dd, input logic z);
    logic pc, lu;
    pc = ms[0].br & z;
    lu = hazard(dd);
    if (pc && mflush < 65535) mflush++;
    if (!pc && lu && mstall < 65535) mstall++;
    ms[2] = ms[1];
    ms[1] = ms[0];
    ms[0] = (pc || lu) ? cw_t'(0) : dd;
  endtask

  task automatic check_model;
    chk("rand_comb", 64'(comb_a), 64'(exp_comb(d, ZeroE)));
    chk("rand_E", 64'(e_a), 64'(ms[0]));
    chk("rand_M", 64'(m_a), 64'({ms[1].rw, ms[1].mw, ms[1].rs, ms[1].rd}));
    chk("rand_W", 64'(w_a), 64'({ms[2].rw, ms[2].rs, ms[2].rd}));
    chk("rand_StallCnt", 64'(StallCnt), 64'(mstall));
    chk("rand_FlushCnt", 64'(FlushCnt), 64'(mflush));
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  vec_t tbl[9];

  initial begin
    // comb = {StallF,StallD,FlushD,FlushE,PCSrcE,ForwardAE,ForwardBE}; st = {RegWriteE,MemWriteE,MemWriteM,RegWriteW}
    tbl[0] = '{LW,   1'b0, 9'b0000_0_00_00, 4'b0000};
    tbl[1] = '{ADD,  1'b0, 9'b1101_0_00_00, 4'b1000};
    tbl[2] = '{ADD,  1'b0, 9'b0000_0_00_00, 4'b0000};
    tbl[3] = '{SW,   1'b0, 9'b0000_0_01_00, 4'b1001};
    tbl[4] = '{NOP,  1'b0, 9'b0000_0_00_10, 4'b0100};
    tbl[5] = '{NOP,  1'b0, 9'b0000_0_00_00, 4'b0011};
    tbl[6] = '{BEQ,  1'b0, 9'b0000_0_00_00, 4'b0000};
    tbl[7] = '{ADD1, 1'b1, 9'b0011_1_00_00, 4'b0000};
    tbl[8] = '{NOP,  1'b1, 9'b0000_0_00_00, 4'b0000};
    #2;
    chk("reset_comb", 64'(comb_a), 64'd0);
    chk("reset_regs", 64'({e_a, m_a, w_a, StallCnt, FlushCnt}), 64'd0);
    #10 rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      d = tbl[i].d;
      ZeroE = tbl[i].z;
      #2;
      chk($sformatf("vec%0d_comb", i), 64'(comb_a), 64'(tbl[i].comb));
      chk($sformatf("vec%0d_stage", i), 64'({RegWriteE, MemWriteE, MemWriteM, RegWriteW}), 64'(tbl[i].st));
      tick();
    end
    chk("vec_StallCnt", 64'(StallCnt), 64'd1);
    chk("vec_FlushCnt", 64'(FlushCnt), 64'd1);

    // taken branch wins over a simultaneous load-use condition
    d = LDBR;
    ZeroE = 1'b0;
    tick();
    d = ADD;
    ZeroE = 1'b1;
    #2;
    chk("brlu_ctrl", 64'(comb_a[8:4]), 64'b00111);
    tick();
    chk("brlu_FlushCnt", 64'(FlushCnt), 64'd2);
    chk("brlu_StallCnt", 64'(StallCnt), 64'd1);
    chk("brlu_RegWriteE", 64'(RegWriteE), 64'd0);

    // asynchronous reset in the middle of traffic
    pulse_rst();
    for (int i = 0; i < 5; i++) begin
      d = LW;
      ZeroE = 1'b0;
      tick();
      d = ADD;
      tick();
    end
    chk("pre_rst_StallCnt", 64'(StallCnt), 64'd5);
    chk("pre_rst_RegWriteM", 64'(RegWriteM), 64'd1);
    ZeroE = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_regs", 64'({e_a, m_a, w_a}), 64'd0);
    chk("async_rst_cnts", 64'({StallCnt, FlushCnt}), 64'd0);
    chk("async_rst_PCSrcE", 64'(PCSrcE), 64'd0);
    chk("async_rst_comb", 64'(comb_a), 64'd0);
    #2 rst = 1'b0;
    d = SW;
    ZeroE = 1'b0;
    tick();
    chk("post_rst_E", 64'(e_a), 64'(SW));
    d = NOP;
    tick();
    chk("lat_MemWriteM", 64'(MemWriteM), 64'd1);
    tick();
    chk("lat_RegWriteW", 64'(RegWriteW), 64'd0);

    // FlushCnt saturation on the 4-bit instance
    pulse_rst();
    d = BEQ;
    ZeroE = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    chk("sat_FlushCnt4", 64'(q_fc), 64'd15);
    chk("sat_FlushCnt16", 64'(FlushCnt), 64'd20);
    chk("sat_StallCnt", 64'(StallCnt), 64'd0);

    // randomized traffic against the reference model
    pulse_rst();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      d = cw_t'($urandom);
      d.br = ($urandom_range(0, 3) == 0);
      d.r1 = 5'($urandom_range(0, 3));
      d.r2 = 5'($urandom_range(0, 3));
      d.rd = 5'($urandom_range(0, 3));
      ZeroE = 1'($urandom_range(0, 1));
      #1;
      check_model();
      model_step(d, ZeroE);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
